icache_l2_req_arbiter: RTL and testbench
========================================

# icache_l2_req_arbiter

Sequences and shares the single L1I→L2 request channel between the instruction-cache refill path and the non-cacheable (NC) bypass path. Requests are arbitrated round-robin, and one transaction is outstanding at a time. Each L2 grant is routed back to the requester that owns it. Killed transactions are drained, and hung transactions are recovered by a timeout. It sits between the icache miss logic / NC bypass buffer and the L2/NoC interface.

## Interface
Parameters:
- L2_DATA_WIDTH, 512, L2 response width; the refill line is L2_DATA_WIDTH/8 bytes.
- TIMEOUT_CYCLES, 1024, cycles to wait for a grant before abort; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- refill_req_valid_i  in  1  cached line refill request
- refill_req_addr_i  in  40  refill physical address
- refill_kill_i  in  1  abandon the pending or outstanding refill
- refill_req_ready_o  out  1  refill accepted this cycle
- nc_req_valid_i  in  1  NC bypass request
- nc_req_addr_i  in  40  NC physical address
- nc_kill_i  in  1  abandon the pending or outstanding NC request
- nc_req_ready_o  out  1  NC request accepted this cycle
- l2_req_valid_o  out  1  request to L2
- l2_req_ready_i  in  1  L2 accepts the request
- l2_req_addr_o  out  40  aligned request address
- l2_req_nc_o  out  1  1 = NC (8 B) request, 0 = line refill
- l2_grant_valid_i  in  1  L2 response valid
- l2_resp_data_i  in  L2_DATA_WIDTH  L2 response data
- refill_rsp_valid_o  out  1  one-cycle refill response pulse
- nc_rsp_valid_o  out  1  one-cycle NC response pulse
- rsp_data_o  out  L2_DATA_WIDTH  registered response data
- busy_o  out  1  state ≠ IDLE
- timeout_o  out  1  one-cycle abort pulse

## Operation
- FSM states: IDLE, REQ, WAIT, DRAIN.
- **IDLE**
  - Candidates are refill_req_valid_i & ~refill_kill_i and nc_req_valid_i & ~nc_kill_i.
  - One candidate: it wins.
  - Two candidates: the one not served last wins. The last-owner flop resets to NC, so refill wins the first tie.
  - The winner's ready_o is asserted combinationally this cycle.
  - Address, owner and nc flag are captured; last-owner is updated. Next state is REQ.
- **Address alignment**
  - Refill: low log2(L2_DATA_WIDTH/8) bits zeroed (bits [5:0] at 512).
  - NC: bits [2:0] zeroed.
- **REQ**
  - l2_req_valid_o=1 with stable addr/nc until l2_req_ready_i, then go to WAIT.
  - Valid is never retracted, even if the owner is killed meanwhile. A kill seen in REQ is latched, and the handshake completes into DRAIN instead of WAIT.
- **WAIT**
  - l2_grant_valid_i → capture l2_resp_data_i into rsp_data_o, pulse the owner's rsp_valid_o next cycle, go to IDLE.
  - Owner kill → DRAIN.
  - Kill and grant in the same cycle: kill wins, the response is dropped, go to IDLE.
- **DRAIN**
  - Wait for l2_grant_valid_i, discard it (no rsp pulse, rsp_data_o unchanged), go to IDLE.
- **Timeout**
  - A counter clears on entry to WAIT/DRAIN and increments each cycle there.
  - At TIMEOUT_CYCLES-1 with no grant: timeout_o pulses next cycle, go to IDLE, no rsp pulse.
  - A grant arriving in the same cycle as the limit wins over the timeout.
- Only the owner's kill affects a transaction; the other requester's kill only gates its own acceptance.
- l2_grant_valid_i in IDLE or REQ is illegal and is ignored.

## Timing
- Reset values: state IDLE; all valid/ready/rsp/timeout outputs 0; l2_req_addr_o, l2_req_nc_o and rsp_data_o 0; busy_o 0; counter 0.
- Accept at cycle t.
  - l2_req_valid_o is high from t+1.
  - With ready at t+1, state is WAIT at t+2.
  - A grant at cycle g ≥ t+2 gives rsp_valid_o high and rsp_data_o valid at g+1.
  - State is IDLE at g+1, so the next accept can occur at g+1.
- rsp_data_o holds its value until the next captured grant.
- ready_o and rsp_valid_o are single-cycle pulses.
- Reset mid-transaction returns to IDLE immediately. Any L2 grant that arrives after reset is ignored.

## Test plan
- Refill only: refill valid, addr 0x00_8000_0047, ready at t+1, grant at t+5 with data 0xA5.. → l2_req_addr_o 0x00_8000_0040, nc=0; refill_rsp_valid_o at t+6 with rsp_data_o=0xA5..; nc_rsp_valid_o stays 0.
- NC only: addr 0x00_0000_1006 → l2_req_addr_o 0x00_0000_1000, nc=1; grant → nc_rsp_valid_o pulse only.
- Both valid every cycle from reset → accepts alternate refill, NC, refill, NC; exactly one ready_o per accept.
- nc_kill_i while REQ with l2_req_ready_i low for 3 cycles → l2_req_valid_o held until ready, DRAIN, grant consumed, no rsp pulse, busy_o drops the cycle after the grant.
- TIMEOUT_CYCLES=8, no grant → timeout_o pulse 8 cycles after entering WAIT, back in IDLE, next request is accepted normally.
- Grant and owner kill in the same cycle in WAIT → no rsp pulse, rsp_data_o unchanged, IDLE next cycle.

Source files
------------

// File: rtl/icache_l2_req_arbiter.sv
// icache_l2_req_arbiter
// Shares the single L1I->L2 request channel between the icache refill path
// and the non-cacheable bypass path. Round-robin between the two, one
// transaction in flight, responses steered back to the owner. Killed
// transactions still consume their grant; a stuck one is aborted after
// TIMEOUT_CYCLES (0 disables the abort).
module icache_l2_req_arbiter #(
    parameter int L2_DATA_WIDTH  = 512,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     refill_req_valid_i,
    input  logic [39:0]              refill_req_addr_i,
    input  logic                     refill_kill_i,
    output logic                     refill_req_ready_o,
    input  logic                     nc_req_valid_i,
    input  logic [39:0]              nc_req_addr_i,
    input  logic                     nc_kill_i,
    output logic                     nc_req_ready_o,
    output logic                     l2_req_valid_o,
    input  logic                     l2_req_ready_i,
    output logic [39:0]              l2_req_addr_o,
    output logic                     l2_req_nc_o,
    input  logic                     l2_grant_valid_i,
    input  logic [L2_DATA_WIDTH-1:0] l2_resp_data_i,
    output logic                     refill_rsp_valid_o,
    output logic                     nc_rsp_valid_o,
    output logic [L2_DATA_WIDTH-1:0] rsp_data_o,
    output logic                     busy_o,
    output logic                     timeout_o
);

    localparam int LINE_BYTES = L2_DATA_WIDTH / 8;
    localparam int CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LIM     = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    localparam logic [39:0] LINE_MASK = ~40'(LINE_BYTES - 1);
    localparam logic [39:0] NC_MASK   = ~40'h7;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_e;

    state_e                   state_q, state_d;
    logic                     owner_nc_q, owner_nc_d;   // owner of the in-flight transaction
    logic                     last_nc_q, last_nc_d;     // who was served last (round-robin)
    logic [39:0]              addr_q, addr_d;
    logic                     kill_q, kill_d;           // owner kill seen while still in REQ
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [L2_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                     refill_rsp_q, refill_rsp_d;
    logic                     nc_rsp_q, nc_rsp_d;
    logic                     timeout_q, timeout_d;

    logic cand_rf, cand_nc, pick_nc, own_kill, to_hit;

    // Request candidates, round-robin pick, owner kill and timeout limit.
    always_comb begin
        cand_rf  = refill_req_valid_i & ~refill_kill_i;
        cand_nc  = nc_req_valid_i & ~nc_kill_i;
        // NC wins when alone, or on a tie when refill was served last.
        pick_nc  = cand_nc & (~cand_rf | ~last_nc_q);
        own_kill = owner_nc_q ? nc_kill_i : refill_kill_i;
        to_hit   = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LIM));
    end

    // State and datapath registers; last-owner resets to NC so refill wins the first tie.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= S_IDLE;
            owner_nc_q   <= 1'b0;
            last_nc_q    <= 1'b1;
            addr_q       <= '0;
            kill_q       <= 1'b0;
            cnt_q        <= '0;
            rsp_data_q   <= '0;
            refill_rsp_q <= 1'b0;
            nc_rsp_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_nc_q   <= owner_nc_d;
            last_nc_q    <= last_nc_d;
            addr_q       <= addr_d;
            kill_q       <= kill_d;
            cnt_q        <= cnt_d;
            rsp_data_q   <= rsp_data_d;
            refill_rsp_q <= refill_rsp_d;
            nc_rsp_q     <= nc_rsp_d;
            timeout_q    <= timeout_d;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_d      = state_q;
        owner_nc_d   = owner_nc_q;
        last_nc_d    = last_nc_q;
        addr_d       = addr_q;
        kill_d       = kill_q;
        cnt_d        = cnt_q;
        rsp_data_d   = rsp_data_q;
        refill_rsp_d = 1'b0;
        nc_rsp_d     = 1'b0;
        timeout_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cand_rf | cand_nc) begin
                    owner_nc_d = pick_nc;
                    last_nc_d  = pick_nc;
                    addr_d     = pick_nc ? (nc_req_addr_i & NC_MASK)
                                         : (refill_req_addr_i & LINE_MASK);
                    kill_d     = 1'b0;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                // The request is never retracted; a kill only redirects to DRAIN.
                if (l2_req_ready_i) begin
                    state_d = (kill_q | own_kill) ? S_DRAIN : S_WAIT;
                    cnt_d   = '0;
                end else if (own_kill) begin
                    kill_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (own_kill) begin
                    // Kill beats a same-cycle grant: the response is dropped.
                    state_d = l2_grant_valid_i ? S_IDLE : S_DRAIN;
                    cnt_d   = '0;
                end else if (l2_grant_valid_i) begin
                    rsp_data_d   = l2_resp_data_i;
                    refill_rsp_d = ~owner_nc_q;
                    nc_rsp_d     = owner_nc_q;
                    state_d      = S_IDLE;
                end else if (to_hit) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (l2_grant_valid_i) begin
                    state_d = S_IDLE;
                end else if (to_hit) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: accept strobes are combinational, everything else comes from flops.
    always_comb begin
        refill_req_ready_o = (state_q == S_IDLE) & cand_rf & ~pick_nc;
        nc_req_ready_o     = (state_q == S_IDLE) & pick_nc;
        l2_req_valid_o     = (state_q == S_REQ);
        busy_o             = (state_q != S_IDLE);
        l2_req_addr_o      = addr_q;
        l2_req_nc_o        = owner_nc_q;
        refill_rsp_valid_o = refill_rsp_q;
        nc_rsp_valid_o     = nc_rsp_q;
        rsp_data_o         = rsp_data_q;
        timeout_o          = timeout_q;
    end

endmodule

// File: tb/tb_icache_l2_req_arbiter.sv
// Bench for icache_l2_req_arbiter: directed scenarios followed by random
// transactions, all checked against a transaction-level model of the
// arbitration, alignment, kill, grant and timeout rules.
module tb_icache_l2_req_arbiter;

    localparam int DW = 512;
    localparam int TO = 8;
    localparam longint LINE_B = DW / 8;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          refill_req_valid_i, refill_kill_i, refill_req_ready_o;
    logic [39:0]   refill_req_addr_i;
    logic          nc_req_valid_i, nc_kill_i, nc_req_ready_o;
    logic [39:0]   nc_req_addr_i;
    logic          l2_req_valid_o, l2_req_ready_i, l2_req_nc_o;
    logic [39:0]   l2_req_addr_o;
    logic          l2_grant_valid_i;
    logic [DW-1:0] l2_resp_data_i;
    logic          refill_rsp_valid_o, nc_rsp_valid_o, busy_o, timeout_o;
    logic [DW-1:0] rsp_data_o;

    icache_l2_req_arbiter #(.L2_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .refill_req_valid_i(refill_req_valid_i), .refill_req_addr_i(refill_req_addr_i),
        .refill_kill_i(refill_kill_i), .refill_req_ready_o(refill_req_ready_o),
        .nc_req_valid_i(nc_req_valid_i), .nc_req_addr_i(nc_req_addr_i),
        .nc_kill_i(nc_kill_i), .nc_req_ready_o(nc_req_ready_o),
        .l2_req_valid_o(l2_req_valid_o), .l2_req_ready_i(l2_req_ready_i),
        .l2_req_addr_o(l2_req_addr_o), .l2_req_nc_o(l2_req_nc_o),
        .l2_grant_valid_i(l2_grant_valid_i), .l2_resp_data_i(l2_resp_data_i),
        .refill_rsp_valid_o(refill_rsp_valid_o), .nc_rsp_valid_o(nc_rsp_valid_o),
        .rsp_data_o(rsp_data_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Model state: who was served last, and the response data last delivered.
    bit            last_nc;
    logic [DW-1:0] rsp_exp;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] align(input logic [39:0] a, input bit nc);
        longint unsigned v, sz;
        v  = 64'(a);
        sz = nc ? 64'd8 : 64'(LINE_B);
        return 40'(v - (v % sz));
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic idle_inputs();
        refill_req_valid_i = 0; refill_kill_i = 0; refill_req_addr_i = '0;
        nc_req_valid_i = 0; nc_kill_i = 0; nc_req_addr_i = '0;
        l2_req_ready_i = 0; l2_grant_valid_i = 0; l2_resp_data_i = '0;
    endtask

    // Requester side while a transaction is in flight: optional random
    // activity from both requesters; the owner's kill fires only at kill_now.
    task automatic drive_busy(input bit wnc, input bit kill_now, input bit noise);
        bit ok;
        ok = noise && ($urandom_range(0, 1) == 1);
        refill_req_valid_i = noise && ($urandom_range(0, 1) == 1);
        nc_req_valid_i     = noise && ($urandom_range(0, 1) == 1);
        refill_req_addr_i  = {8'($urandom), $urandom};
        nc_req_addr_i      = {8'($urandom), $urandom};
        refill_kill_i      = wnc ? ok : kill_now;
        nc_kill_i          = wnc ? kill_now : ok;
    endtask

    // One arbitration attempt and, if something wins, its full transaction.
    // Cycle index 0 is the first cycle after acceptance. L2 accepts after
    // rdy_dly stall cycles; the grant comes gnt_dly cycles into WAIT/DRAIN.
    task automatic txn(input bit rv, input bit nv, input bit rk0, input bit nk0,
                       input logic [39:0] ra, input logic [39:0] na,
                       input int rdy_dly, input int gnt_dly, input int kill_cyc,
                       input logic [DW-1:0] data, input bit noise);
        bit crf, cnc, wnc, killed, done, rsp, tmo, g, kn;
        int idx, wn, ton;
        logic [39:0] ea;
        @(negedge clk_i);
        idle_inputs();
        refill_req_valid_i = rv; refill_req_addr_i = ra; refill_kill_i = rk0;
        nc_req_valid_i = nv; nc_req_addr_i = na; nc_kill_i = nk0;
        l2_grant_valid_i = noise && ($urandom_range(0, 1) == 1);
        l2_resp_data_i = rnd_data();
        #1;
        crf = rv && !rk0;
        cnc = nv && !nk0;
        wnc = (crf && cnc) ? !last_nc : cnc;
        chk("idle_busy", busy_o, 0);
        chk("idle_l2_valid", l2_req_valid_o, 0);
        chk("idle_rsp_pulses", {refill_rsp_valid_o, nc_rsp_valid_o, timeout_o}, 0);
        chk("rf_ready", refill_req_ready_o, crf && !wnc);
        chk("nc_ready", nc_req_ready_o, cnc && wnc);
        if (!(crf || cnc)) return;
        last_nc = wnc;
        ea = align(wnc ? na : ra, wnc);
        killed = 0; done = 0; rsp = 0; tmo = 0; idx = 0;

        // REQ phase: request held until L2 takes it.
        for (int k = 0; k <= rdy_dly; k++) begin
            @(negedge clk_i);
            kn = (idx == kill_cyc);
            drive_busy(wnc, kn, noise);
            l2_req_ready_i   = (k == rdy_dly);
            l2_grant_valid_i = noise && ($urandom_range(0, 1) == 1);
            l2_resp_data_i   = rnd_data();
            #1;
            chk("req_valid", l2_req_valid_o, 1);
            chk("req_addr", l2_req_addr_o, ea);
            chk("req_nc", l2_req_nc_o, wnc);
            chk("req_busy", busy_o, 1);
            chk("req_readies", {refill_req_ready_o, nc_req_ready_o}, 0);
            if (kn) killed = 1;
            idx++;
        end

        // WAIT/DRAIN phase: grant, kill or timeout ends it.
        wn = 0; ton = 0;
        while (!done) begin
            @(negedge clk_i);
            kn = (idx == kill_cyc);
            drive_busy(wnc, kn, noise);
            l2_req_ready_i   = noise && ($urandom_range(0, 1) == 1);
            g                = (wn == gnt_dly);
            l2_grant_valid_i = g;
            l2_resp_data_i   = g ? data : rnd_data();
            #1;
            chk("wait_l2_valid", l2_req_valid_o, 0);
            chk("wait_busy", busy_o, 1);
            chk("wait_readies", {refill_req_ready_o, nc_req_ready_o}, 0);
            chk("wait_pulses", {refill_rsp_valid_o, nc_rsp_valid_o, timeout_o}, 0);
            if (g) begin
                done = 1;
                rsp  = !(killed || kn);
            end else if (kn && !killed) begin
                killed = 1;
                ton    = 0;
            end else if (ton == TO - 1) begin
                done = 1;
                tmo  = 1;
            end else begin
                ton++;
            end
            wn++; idx++;
        end

        // Cycle after completion: back in IDLE with the outcome pulses.
        @(negedge clk_i);
        idle_inputs();
        #1;
        if (rsp) rsp_exp = data;
        chk("end_rf_rsp", refill_rsp_valid_o, rsp && !wnc);
        chk("end_nc_rsp", nc_rsp_valid_o, rsp && wnc);
        chk("end_timeout", timeout_o, tmo);
        chk("end_rsp_data", rsp_data_o, rsp_exp);
        chk("end_busy", busy_o, 0);
        chk("end_l2_valid", l2_req_valid_o, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        idle_inputs();
        rstn_i  = 0;
        last_nc = 1;
        rsp_exp = '0;

        // Reset values
        #12;
        chk("rst_busy", busy_o, 0);
        chk("rst_l2_valid", l2_req_valid_o, 0);
        chk("rst_addr", l2_req_addr_o, 0);
        chk("rst_nc", l2_req_nc_o, 0);
        chk("rst_rsp_data", rsp_data_o, 0);
        chk("rst_pulses", {refill_rsp_valid_o, nc_rsp_valid_o, timeout_o}, 0);
        @(negedge clk_i);
        rstn_i = 1;

        // Refill only: grant 5 cycles after the accept
        txn(1, 0, 0, 0, 40'h00_8000_0047, 40'h0, 0, 3, -1, {64{8'hA5}}, 0);
        // NC only
        txn(0, 1, 0, 0, 40'h0, 40'h00_0000_1006, 0, 1, -1, rnd_data(), 0);
        // Both requesting: alternate starting from refill after the NC above
        for (int i = 0; i < 4; i++)
            txn(1, 1, 0, 0, 40'h12_3456_78FF, 40'h00_0BAD_F00D, 0, 1, -1, rnd_data(), 0);
        // NC killed while L2 stalls the request for 3 cycles
        txn(0, 1, 0, 0, 40'h0, 40'h00_0000_2222, 3, 2, 1, rnd_data(), 0);
        // No grant: timeout, then a normal request
        txn(1, 0, 0, 0, 40'h00_4000_0000, 40'h0, 0, 100, -1, rnd_data(), 0);
        txn(1, 0, 0, 0, 40'h00_4000_0080, 40'h0, 0, 0, -1, rnd_data(), 0);
        // Grant exactly at the timeout limit wins
        txn(0, 1, 0, 0, 40'h0, 40'h00_0000_3003, 0, TO - 1, -1, rnd_data(), 0);
        // Grant and owner kill together in WAIT
        txn(1, 0, 0, 0, 40'h00_5555_5555, 40'h0, 0, 2, 3, rnd_data(), 0);
        // A killed requester does not compete
        txn(1, 1, 1, 0, 40'h00_6000_0000, 40'h00_7000_0001, 0, 0, -1, rnd_data(), 0);
        txn(1, 1, 0, 1, 40'h00_6000_0000, 40'h00_7000_0001, 0, 0, -1, rnd_data(), 0);

        // Random transactions with noise on the unrelated inputs
        for (int n = 0; n < 60; n++) begin
            bit rv, nv, rk, nk;
            int rd, gd, kc;
            rv = ($urandom_range(0, 3) != 0);
            nv = ($urandom_range(0, 3) != 0);
            rk = ($urandom_range(0, 4) == 0);
            nk = ($urandom_range(0, 4) == 0);
            rd = $urandom_range(0, 3);
            gd = $urandom_range(0, 10);
            kc = ($urandom_range(0, 2) == 0) ? $urandom_range(0, rd + 4) : -1;
            txn(rv, nv, rk, nk, {8'($urandom), $urandom}, {8'($urandom), $urandom},
                rd, gd, kc, rnd_data(), 1);
        end

        // Reset during WAIT: immediate IDLE, the late grant is ignored
        @(negedge clk_i);
        idle_inputs();
        refill_req_valid_i = 1; refill_req_addr_i = 40'h00_9000_0000;
        @(negedge clk_i);
        idle_inputs();
        l2_req_ready_i = 1;
        @(negedge clk_i);
        idle_inputs();
        #1;
        chk("pre_rst_busy", busy_o, 1);
        rstn_i = 0;
        #1;
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_data", rsp_data_o, 0);
        last_nc = 1;
        rsp_exp = '0;
        @(negedge clk_i);
        rstn_i = 1;
        d = rnd_data();
        l2_grant_valid_i = 1; l2_resp_data_i = d;
        @(negedge clk_i);
        idle_inputs();
        #1;
        chk("post_rst_pulses", {refill_rsp_valid_o, nc_rsp_valid_o, timeout_o}, 0);
        chk("post_rst_data", rsp_data_o, 0);
        chk("post_rst_busy", busy_o, 0);
        // First tie after reset goes to refill
        txn(1, 1, 0, 0, 40'h00_0000_1040, 40'h00_0000_2008, 1, 2, -1, rnd_data(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
